pipe_in_check: RTL and testbench
================================

Name: pipe_in_check

Overview:
Sink-side checker for Pipe In verification; the consumer end of the pattern stream that the Pipe Out test source generates. Accepts 32-bit words from the host Pipe In endpoint and compares each against a locally regenerated expected pattern. Counts words and mismatches, and paces the host through a virtual FIFO drained by a circular throttle register.

Parameters:
LEVEL_W, 16, virtual FIFO level width; LEVEL_MAX = 2^LEVEL_W-1
READY_THRESH, 1024, free space (words) required to assert pipe_in_ready

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
pipe_in_write  in  1  host write strobe, one word per asserted cycle
pipe_in_data  in  32  host write data, valid when pipe_in_write=1
pipe_in_ready  out  1  registered; space for one READY_THRESH block
throttle_set  in  1  load throttle from throttle_val
throttle_val  in  32  throttle pattern
fixed_pattern  in  32  value used by mode 0
pattern  in  3  expected-data mode
word_count  out  32  words accepted since reset, saturating
error_count  out  32  mismatches since reset, saturating
error_flag  out  1  sticky, set on first mismatch
overflow_flag  out  1  sticky, write seen with level==LEVEL_MAX
first_err_index  out  32  word_count value of first mismatching word (feature only)
first_err_data  out  32  received value of first mismatch (feature only)
first_err_expected  out  32  expected value of first mismatch (feature only)

Behaviour:
- Reset: pipe_in_ready=0, level=0, all counters/flags/first_err_*=0, throttle<=throttle_val, generator reseeded, pipeline valid bits cleared. In-flight compares are discarded.
- Expected generator advances only on pipe_in_write. Modes:
  - 0 = fixed_pattern.
  - 1 = count, first word 0x00000001, +1 per word, wraps at 2^32.
  - 2 = 32-bit Fibonacci LFSR, taps 32,22,2,1, seed 0x04030201, shifted left, feedback into bit 0.
  - 3 = walking one, starts 0x00000001, rotate left.
  - 4 = walking zero, bitwise inverse of mode 3.
  - 5-7 behave as mode 0.
- Pattern changes take effect on the next write without reseeding.
- Pipeline:
  - Cycle N: write sampled.
  - N+1: registered data, expected, valid; word_count increments.
  - N+2: compare result applied; on mismatch error_count +1 and error_flag set.
- Writes are checked regardless of pipe_in_ready.
- Virtual FIFO, case {pipe_in_write, throttle[0]}:
  - 10: level+1, saturating at LEVEL_MAX. A write at LEVEL_MAX sets overflow_flag.
  - 01: level-1, floor 0.
  - 00 and 11: no change.
- pipe_in_ready <= (level + READY_THRESH <= LEVEL_MAX), evaluated on the current level; one cycle of lag, first assertion one cycle after reset deasserts.
- Throttle: throttle_set loads throttle_val, else rotates right by 1 each cycle. throttle_set has priority over the rotate.
- Counters saturate at 0xFFFFFFFF; sticky flags clear only on reset.

Optional Feature:
PIPE_IN_CHECK_FIRST_ERR_EN:
- Defined: on the first mismatch only (error_flag was 0), latch first_err_index (1-based word number), first_err_data and first_err_expected in the same cycle error_flag sets. Later mismatches leave them unchanged.
- Undefined: these three outputs are tied to 0 and no capture registers are built.

Decomposition:
- Shared package: pattern mode constants (PAT_FIXED=0, PAT_COUNT=1, PAT_LFSR=2, PAT_WALK1=3, PAT_WALK0=4), LFSR seed, tap mask.
- One sub-module: the existing shared pattern generator, instanced with WIDTH=32 and enable=pipe_in_write. It is already used by the Pipe Out source, so both ends stay bit-identical.

Test Plan:
1. Mode 1, throttle 0xFFFFFFFF, write 0x1..0x100 back-to-back -> word_count=256, error_count=0, error_flag=0, pipe_in_ready stays 1.
2. Mode 1, fifth word written as 0xDEADBEEF -> two cycles after that write, error_count=1 and error_flag=1; with feature, first_err_index=5, data 0xDEADBEEF, expected 0x00000005. Later correct words leave error_count at 1.
3. throttle_val=0 (no drain), continuous writes -> ready is 1 while level<=64511 and falls the cycle after the 64512th write. Write 1024 more -> overflow_flag=1 only after level reaches 65535 and one further write occurs.
4. throttle_val=0x00000001, write asserted every cycle -> level net +31 per 32 cycles, no change on the drain cycle; throttle_set mid-stream with 0xFFFFFFFF -> level thereafter constant.
5. Mode 2, 1000 words generated by a reference LFSR with the same taps and seed -> error_count=0; flip bit 0 of word 500 -> error_count=1.
6. Reset asserted one cycle after a mismatching write -> error_count stays 0, all outputs at reset values. The next write is compared against the seed value (0x00000001 in mode 1).

Source files
------------

// File: rtl/pipe_in_check_pkg.sv
// rtl/pipe_in_check_pkg.sv - Pattern modes and LFSR constants shared by the Pipe In checker and Pipe Out source.
package pipe_in_check_pkg;

  typedef enum logic [2:0] {
    PAT_FIXED = 3'd0,
    PAT_COUNT = 3'd1,
    PAT_LFSR  = 3'd2,
    PAT_WALK1 = 3'd3,
    PAT_WALK0 = 3'd4
  } pat_mode_e;

  localparam logic [31:0] LFSR_SEED = 32'h0403_0201;
  // Taps 32,22,2,1 expressed as bit positions 31,21,1,0
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

endpackage

// File: rtl/pipe_in_check_if.sv
// rtl/pipe_in_check_if.sv - Host Pipe In write port: strobe, data and ready.
interface pipe_in_check_if;
  logic        pipe_in_write;
  logic [31:0] pipe_in_data;
  logic        pipe_in_ready;

  modport master (output pipe_in_write, output pipe_in_data, input pipe_in_ready);
  modport slave  (input pipe_in_write, input pipe_in_data, output pipe_in_ready);
endinterface

// File: rtl/pipe_in_check_pattern_gen.sv
// rtl/pipe_in_check_pattern_gen.sv - Shared pattern generator; presents the current word and steps on enable.
module pipe_in_check_pattern_gen
  import pipe_in_check_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable_i,
  input  logic [2:0]       mode_i,
  input  logic [WIDTH-1:0] fixed_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] lfsr_q;
  logic [WIDTH-1:0] walk_q;

  // All generators step together so a mode switch picks up mid-sequence
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= WIDTH'(1);
      lfsr_q <= WIDTH'(LFSR_SEED);
      walk_q <= WIDTH'(1);
    end else if (enable_i) begin
      cnt_q  <= cnt_q + WIDTH'(1);
      lfsr_q <= {lfsr_q[WIDTH-2:0], ^(lfsr_q & WIDTH'(LFSR_TAPS))};
      walk_q <= {walk_q[WIDTH-2:0], walk_q[WIDTH-1]};
    end
  end

  always_comb begin
    data_o = fixed_i;
    case (mode_i)
      PAT_COUNT: data_o = cnt_q;
      PAT_LFSR:  data_o = lfsr_q;
      PAT_WALK1: data_o = walk_q;
      PAT_WALK0: data_o = ~walk_q;
      default:   data_o = fixed_i;
    endcase
  end

endmodule

// File: rtl/pipe_in_check.sv
// rtl/pipe_in_check.sv - Pipe In sink checker with virtual-FIFO pacing.
// PIPE_IN_CHECK_FIRST_ERR_EN adds first-mismatch capture registers.
module pipe_in_check
  import pipe_in_check_pkg::*;
#(
  parameter int LEVEL_W      = 16,
  parameter int READY_THRESH = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  pipe_in_check_if.slave       pipe_in,
  input  logic                 throttle_set,
  input  logic [31:0]          throttle_val,
  input  logic [31:0]          fixed_pattern,
  input  logic [2:0]           pattern,
  output logic [31:0]          word_count,
  output logic [31:0]          error_count,
  output logic                 error_flag,
  output logic                 overflow_flag,
  output logic [31:0]          first_err_index,
  output logic [31:0]          first_err_data,
  output logic [31:0]          first_err_expected
);

  localparam logic [LEVEL_W-1:0] LEVEL_MAX = '1;

  logic              wr;
  logic [31:0]       expected;
  logic [31:0]       data_q, exp_q;
  logic              valid_q;
  logic              mismatch;
  logic [31:0]       word_count_q, error_count_q;
  logic              error_flag_q, overflow_q, ready_q;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic              overflow_d;
  logic [31:0]       throttle_q, throttle_d;

  assign wr       = pipe_in.pipe_in_write;
  assign mismatch = valid_q && (data_q != exp_q);

  pipe_in_check_pattern_gen #(.WIDTH(32)) u_gen (
    .clk      (clk),
    .reset    (reset),
    .enable_i (wr),
    .mode_i   (pattern),
    .fixed_i  (fixed_pattern),
    .data_o   (expected)
  );

  always_comb begin
    level_d    = level_q;
    overflow_d = overflow_q;
    case ({wr, throttle_q[0]})
      2'b10: begin
        if (level_q == LEVEL_MAX) overflow_d = 1'b1;
        else                      level_d    = level_q + 1'b1;
      end
      2'b01:   if (level_q != '0) level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    throttle_d = throttle_set ? throttle_val : {throttle_q[0], throttle_q[31:1]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q        <= '0;
      exp_q         <= '0;
      valid_q       <= 1'b0;
      word_count_q  <= '0;
      error_count_q <= '0;
      error_flag_q  <= 1'b0;
      overflow_q    <= 1'b0;
      level_q       <= '0;
      ready_q       <= 1'b0;
      throttle_q    <= throttle_val;
    end else begin
      data_q     <= pipe_in.pipe_in_data;
      exp_q      <= expected;
      valid_q    <= wr;
      if (wr && word_count_q != '1) word_count_q <= word_count_q + 1'b1;
      if (mismatch) begin
        error_flag_q <= 1'b1;
        if (error_count_q != '1) error_count_q <= error_count_q + 1'b1;
      end
      overflow_q <= overflow_d;
      level_q    <= level_d;
      // Ready looks at the level before this cycle's update, hence one cycle of lag
      ready_q    <= ({1'b0, level_q} + (LEVEL_W+1)'(READY_THRESH)) <= {1'b0, LEVEL_MAX};
      throttle_q <= throttle_d;
    end
  end

`ifdef PIPE_IN_CHECK_FIRST_ERR_EN
  logic [31:0] fe_index_q, fe_data_q, fe_exp_q;

  // word_count_q already includes the word being compared, giving a 1-based index
  always_ff @(posedge clk) begin
    if (reset) begin
      fe_index_q <= '0;
      fe_data_q  <= '0;
      fe_exp_q   <= '0;
    end else if (mismatch && !error_flag_q) begin
      fe_index_q <= word_count_q;
      fe_data_q  <= data_q;
      fe_exp_q   <= exp_q;
    end
  end

  assign first_err_index    = fe_index_q;
  assign first_err_data     = fe_data_q;
  assign first_err_expected = fe_exp_q;
`else
  assign first_err_index    = '0;
  assign first_err_data     = '0;
  assign first_err_expected = '0;
`endif

  assign pipe_in.pipe_in_ready = ready_q;
  assign word_count            = word_count_q;
  assign error_count           = error_count_q;
  assign error_flag            = error_flag_q;
  assign overflow_flag         = overflow_q;

endmodule

// File: tb/tb_pipe_in_check.sv
// tb/tb_pipe_in_check.sv - Directed table-driven bench for pipe_in_check.
module tb_pipe_in_check;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        throttle_set = 1'b0;
  logic [31:0] throttle_val = 32'hFFFF_FFFF;
  logic [31:0] fixed_pattern = '0;
  logic [2:0]  pattern = 3'd1;
  logic [31:0] word_count, error_count;
  logic        error_flag, overflow_flag;
  logic [31:0] first_err_index, first_err_data, first_err_expected;

  int n_cmp = 0;
  int n_bad = 0;

  pipe_in_check_if pif ();

  pipe_in_check dut (
    .clk                (clk),
    .reset              (reset),
    .pipe_in            (pif),
    .throttle_set       (throttle_set),
    .throttle_val       (throttle_val),
    .fixed_pattern      (fixed_pattern),
    .pattern            (pattern),
    .word_count         (word_count),
    .error_count        (error_count),
    .error_flag         (error_flag),
    .overflow_flag      (overflow_flag),
    .first_err_index    (first_err_index),
    .first_err_data     (first_err_data),
    .first_err_expected (first_err_expected)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  mode;
    logic [31:0] fixed;
    int          nwords;
    int          bad_idx;
    logic [31:0] bad_xor;
    int          exp_errs;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    pif.pipe_in_write = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_vec(input int k, input vec_t v);
    logic [31:0] cnt, lfsr, walk, e, d, fe_data, fe_exp;
    int ready_low;
    throttle_val  = 32'hFFFF_FFFF;
    pattern       = v.mode;
    fixed_pattern = v.fixed;
    do_reset();
    cnt = 32'h1; lfsr = 32'h0403_0201; walk = 32'h1;
    ready_low = 0; fe_data = '0; fe_exp = '0;
    for (int i = 1; i <= v.nwords; i++) begin
      case (v.mode)
        3'd1:    e = cnt;
        3'd2:    e = lfsr;
        3'd3:    e = walk;
        3'd4:    e = ~walk;
        default: e = v.fixed;
      endcase
      d = (i == v.bad_idx) ? (e ^ v.bad_xor) : e;
      if (i == v.bad_idx) begin fe_data = d; fe_exp = e; end
      @(negedge clk);
      if (pif.pipe_in_ready !== 1'b1) ready_low++;
      pif.pipe_in_write = 1'b1;
      pif.pipe_in_data  = d;
      cnt  = cnt + 1;
      lfsr = {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
      walk = {walk[30:0], walk[31]};
    end
    @(negedge clk);
    pif.pipe_in_write = 1'b0;
    repeat (2) @(negedge clk);
    check($sformatf("v%0d word_count", k), word_count, v.nwords);
    check($sformatf("v%0d error_count", k), error_count, v.exp_errs);
    check($sformatf("v%0d error_flag", k), {31'd0, error_flag}, (v.exp_errs != 0) ? 32'd1 : 32'd0);
    check($sformatf("v%0d overflow_flag", k), {31'd0, overflow_flag}, 32'd0);
    check($sformatf("v%0d ready_low_cycles", k), ready_low, 32'd0);
`ifdef PIPE_IN_CHECK_FIRST_ERR_EN
    check($sformatf("v%0d first_err_index", k), first_err_index, v.bad_idx);
    check($sformatf("v%0d first_err_data", k), first_err_data, fe_data);
    check($sformatf("v%0d first_err_expected", k), first_err_expected, fe_exp);
`else
    check($sformatf("v%0d first_err_index", k), first_err_index, 32'd0);
    check($sformatf("v%0d first_err_data", k), first_err_data, 32'd0);
    check($sformatf("v%0d first_err_expected", k), first_err_expected, 32'd0);
`endif
  endtask

  initial begin
    pif.pipe_in_write = 1'b0;
    pif.pipe_in_data  = '0;

    vecs[0] = '{3'd0, 32'hA5A5_5A5A, 20,   0,   32'h0,         0};
    vecs[1] = '{3'd1, 32'h0,         256,  0,   32'h0,         0};
    vecs[2] = '{3'd1, 32'h0,         10,   5,   32'hDEAD_BEEA, 1};
    vecs[3] = '{3'd2, 32'h0,         1000, 0,   32'h0,         0};
    vecs[4] = '{3'd2, 32'h0,         1000, 500, 32'h1,         1};
    vecs[5] = '{3'd3, 32'h0,         40,   0,   32'h0,         0};
    vecs[6] = '{3'd4, 32'h0,         40,   33,  32'h100,       1};
    vecs[7] = '{3'd6, 32'h1234_5678, 8,    1,   32'hFFFF_FFFF, 1};

    for (int k = 0; k < 8; k++) run_vec(k, vecs[k]);

    // Reset one cycle after a mismatching write discards the in-flight compare
    pattern = 3'd1; throttle_val = 32'hFFFF_FFFF;
    do_reset();
    pif.pipe_in_write = 1'b1; pif.pipe_in_data = 32'h0000_0BAD;
    @(negedge clk);
    pif.pipe_in_write = 1'b0; reset = 1'b1;
    @(negedge clk);
    check("rst word_count", word_count, 32'd0);
    check("rst error_count", error_count, 32'd0);
    check("rst error_flag", {31'd0, error_flag}, 32'd0);
    check("rst overflow_flag", {31'd0, overflow_flag}, 32'd0);
    check("rst ready", {31'd0, pif.pipe_in_ready}, 32'd0);
    check("rst first_err_index", first_err_index, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rst ready after release", {31'd0, pif.pipe_in_ready}, 32'd1);
    pif.pipe_in_write = 1'b1; pif.pipe_in_data = 32'h0000_0001;
    @(negedge clk);
    pif.pipe_in_write = 1'b0;
    repeat (3) @(negedge clk);
    check("post-rst error_count", error_count, 32'd0);
    check("post-rst word_count", word_count, 32'd1);

    // Drain pattern 0x1: one no-change cycle then 31 increments per period
    @(negedge clk);
    reset = 1'b1; throttle_val = 32'h0000_0001;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 1; i <= 64; i++) begin
      pif.pipe_in_write = 1'b1; pif.pipe_in_data = i;
      @(negedge clk);
      if (i == 32) check("thr level@32", 32'(dut.level_q), 32'd31);
      if (i == 64) check("thr level@64", 32'(dut.level_q), 32'd62);
    end
    pif.pipe_in_data = 32'd65; throttle_set = 1'b1; throttle_val = 32'hFFFF_FFFF;
    @(negedge clk);
    throttle_set = 1'b0;
    for (int i = 66; i < 106; i++) begin
      pif.pipe_in_data = i;
      @(negedge clk);
    end
    check("thr level held", 32'(dut.level_q), 32'd62);
    pif.pipe_in_write = 1'b0;
    repeat (10) @(negedge clk);
    check("thr drain 10", 32'(dut.level_q), 32'd52);
    repeat (60) @(negedge clk);
    check("thr drain floor", 32'(dut.level_q), 32'd0);

    // No drain: ready threshold and overflow boundary
    throttle_val = 32'h0;
    do_reset();
    for (int i = 1; i <= 65536; i++) begin
      pif.pipe_in_write = 1'b1; pif.pipe_in_data = i;
      @(negedge clk);
      if (i == 64512) check("fill ready@64512", {31'd0, pif.pipe_in_ready}, 32'd1);
      if (i == 64513) check("fill ready@64513", {31'd0, pif.pipe_in_ready}, 32'd0);
      if (i == 65535) check("fill overflow@65535", {31'd0, overflow_flag}, 32'd0);
      if (i == 65536) check("fill overflow@65536", {31'd0, overflow_flag}, 32'd1);
    end
    pif.pipe_in_write = 1'b0;
    repeat (3) @(negedge clk);
    check("fill error_count", error_count, 32'd0);
    check("fill word_count", word_count, 32'd65536);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
